// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, FSM state and operand types for the keypad calculator
//
// Purpose: shared definitions imported by calc_alu, calculator and the bench.
// Ports:   none (package).
package calc_pkg;

  // keycode[4] set means keycode[3:0] is a hex digit; otherwise it is a command.
  localparam int DIGIT_FLAG_BIT = 4;

  localparam logic [3:0] KEY_BACK = 4'h1;
  localparam logic [3:0] KEY_MULT = 4'h2;
  localparam logic [3:0] KEY_SUBT = 4'h3;
  localparam logic [3:0] KEY_EQLS = 4'h4;
  localparam logic [3:0] KEY_CA   = 4'h9;
  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_CE   = 4'hC;

  typedef enum logic [2:0] {
    IDLE_A,
    ENTER_A,
    OP_WAIT,
    ENTER_B,
    RESULT
  } calc_state_t;

  // Sign-magnitude accumulator value.
  typedef struct packed {
    logic        neg;
    logic [15:0] mag;
  } sm_operand_t;

  function automatic logic is_arith_op(input logic [3:0] code);
    return (code == KEY_ADD) || (code == KEY_SUBT) || (code == KEY_MULT);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational add/subtract/multiply on a sign-magnitude accumulator
//
// Purpose: evaluates (a_neg, a_mag) op b and folds the result back to sign-magnitude.
// Ports:
//   op     in  pending operator code (KEY_ADD / KEY_SUBT / KEY_MULT)
//   a_neg  in  sign of operand A
//   a_mag  in  magnitude of operand A
//   b      in  unsigned operand B
//   r_neg  out result sign (never set for zero or on overflow)
//   r_mag  out result magnitude (zero on overflow)
//   ovf    out |result| does not fit in 16 bits
module calc_alu
  import calc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic        a_neg,
  input  logic [15:0] a_mag,
  input  logic [15:0] b,
  output logic        r_neg,
  output logic [15:0] r_mag,
  output logic        ovf
);

  // 34 bits holds the worst case, (2^16-1)^2 with sign, without wrapping.
  logic signed [33:0] a_s;
  logic signed [33:0] b_s;
  logic signed [33:0] r_s;
  logic        [33:0] r_abs;

  always_comb begin
    a_s = a_neg ? -$signed({18'd0, a_mag}) : $signed({18'd0, a_mag});
    b_s = $signed({18'd0, b});

    case (op)
      KEY_SUBT: r_s = a_s - b_s;
      KEY_MULT: r_s = a_s * b_s;
      default:  r_s = a_s + b_s;
    endcase

    r_abs = r_s[33] ? $unsigned(-r_s) : $unsigned(r_s);
    ovf   = |r_abs[33:16];
    r_mag = ovf ? 16'd0 : r_abs[15:0];
    // A negative result is necessarily nonzero, so zero always comes out positive.
    r_neg = !ovf && r_s[33];
  end

endmodule

// File: rtl/calculator.sv
// rtl/calculator.sv - keypad-driven 16-bit hex four-function calculator
//
// Purpose: decodes key strobes, accumulates hex entry and applies chained
//          add/subtract/multiply on a sign-magnitude accumulator.
// Ports:
//   clock    in  rising-edge clock
//   reset    in  synchronous active-high clear
//   newkey   in  single-cycle key strobe
//   keycode  in  [4]=digit flag, [3:0]=digit or command code
//   value    out displayed magnitude (registered)
//   sign     out displayed value is negative (registered)
//   ovw      out sticky overflow flag
module calculator
  import calc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        newkey,
  input  logic [4:0]  keycode,
  output logic [15:0] value,
  output logic        sign,
  output logic        ovw
);

  calc_state_t state, state_nxt;
  sm_operand_t acc, acc_nxt;
  logic [15:0] entry, entry_nxt;
  logic [3:0]  op, op_nxt;
  logic        ovw_nxt;

  logic        alu_neg;
  logic [15:0] alu_mag;
  logic        alu_ovf;

  logic        is_digit;
  logic [3:0]  code;
  logic        clear_all;

  assign is_digit  = keycode[DIGIT_FLAG_BIT];
  assign code      = keycode[3:0];
  assign clear_all = reset || (newkey && !is_digit && (code == KEY_CA));

  calc_alu u_alu (
    .op    (op),
    .a_neg (acc.neg),
    .a_mag (acc.mag),
    .b     (entry),
    .r_neg (alu_neg),
    .r_mag (alu_mag),
    .ovf   (alu_ovf)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    entry_nxt = entry;
    op_nxt    = op;
    ovw_nxt   = ovw;

    if (newkey) begin
      if (is_digit) begin
        case (state)
          IDLE_A, RESULT: begin
            entry_nxt = {12'd0, code};
            state_nxt = ENTER_A;
          end
          OP_WAIT: begin
            entry_nxt = {12'd0, code};
            state_nxt = ENTER_B;
          end
          default: begin
            // A full four-digit entry refuses further digits rather than wrapping.
            if (entry[15:12] == 4'd0) entry_nxt = {entry[11:0], code};
          end
        endcase
      end else if (code == KEY_BACK) begin
        if (state == ENTER_A || state == ENTER_B) entry_nxt = entry >> 4;
      end else if (code == KEY_CE) begin
        entry_nxt = 16'd0;
        if (state == ENTER_B) state_nxt = OP_WAIT;
      end else if (is_arith_op(code)) begin
        if (state == ENTER_A) begin
          acc_nxt.mag = entry;
          acc_nxt.neg = 1'b0;
        end else if (state == ENTER_B) begin
          // Chaining: the previous operator is resolved before the new one is latched.
          acc_nxt.mag = alu_mag;
          acc_nxt.neg = alu_neg;
          if (alu_ovf) ovw_nxt = 1'b1;
        end
        op_nxt    = code;
        state_nxt = OP_WAIT;
        // OP_WAIT always holds a zero entry so EQLS with nothing typed uses B = 0.
        entry_nxt = 16'd0;
      end else if (code == KEY_EQLS) begin
        if (state == ENTER_B || state == OP_WAIT) begin
          acc_nxt.mag = alu_mag;
          acc_nxt.neg = alu_neg;
          if (alu_ovf) ovw_nxt = 1'b1;
          state_nxt = RESULT;
          entry_nxt = 16'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear_all) begin
      state <= IDLE_A;
      acc   <= '0;
      entry <= 16'd0;
      op    <= KEY_ADD;
      ovw   <= 1'b0;
      value <= 16'd0;
      sign  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      entry <= entry_nxt;
      op    <= op_nxt;
      ovw   <= ovw_nxt;
      // Display is registered from next-state values so it is valid right after the key edge.
      if (state_nxt == ENTER_A || state_nxt == ENTER_B) begin
        value <= entry_nxt;
        sign  <= 1'b0;
      end else begin
        value <= acc_nxt.mag;
        sign  <= acc_nxt.neg;
      end
    end
  end

endmodule

// File: tb/tb_calculator.sv
// tb/tb_calculator.sv - self-checking bench for the keypad calculator
module tb_calculator;
  import calc_pkg::*;

  logic        clock;
  logic        reset;
  logic        newkey;
  logic [4:0]  keycode;
  logic [15:0] value;
  logic        sign;
  logic        ovw;

  int n_cmp;
  int n_bad;

  // Reference model: accumulator as a plain signed integer.
  longint     m_acc;
  int         m_entry;
  logic [3:0] m_op;
  bit         m_ovw;
  bit         m_typing;    // display shows the entry being typed
  bit         m_after_op;  // an operator is waiting for its second operand

  calculator dut (
    .clock   (clock),
    .reset   (reset),
    .newkey  (newkey),
    .keycode (keycode),
    .value   (value),
    .sign    (sign),
    .ovw     (ovw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] dig(input int d);
    logic [3:0] v;
    v = 4'(d);
    return {1'b1, v};
  endfunction

  function automatic logic [4:0] cmd(input logic [3:0] c);
    return {1'b0, c};
  endfunction

  task automatic model_clear();
    m_acc = 0; m_entry = 0; m_op = KEY_ADD; m_ovw = 0; m_typing = 0; m_after_op = 0;
  endtask

  task automatic model_eval();
    longint r;
    case (m_op)
      KEY_SUBT: r = m_acc - longint'(m_entry);
      KEY_MULT: r = m_acc * longint'(m_entry);
      default:  r = m_acc + longint'(m_entry);
    endcase
    if (r > 65535 || r < -65535) begin
      m_ovw = 1;
      m_acc = 0;
    end else begin
      m_acc = r;
    end
  endtask

  task automatic model_key(input logic [4:0] k);
    if (k[4]) begin
      if (!m_typing) begin
        m_entry  = int'(k[3:0]);
        m_typing = 1;
      end else if (m_entry < 'h1000) begin
        m_entry = m_entry * 16 + int'(k[3:0]);
      end
    end else begin
      case (k[3:0])
        KEY_CA:   model_clear();
        KEY_BACK: if (m_typing) m_entry = m_entry / 16;
        KEY_CE: begin
          m_entry = 0;
          if (m_typing && m_after_op) m_typing = 0;
        end
        KEY_ADD, KEY_SUBT, KEY_MULT: begin
          if (m_typing) begin
            if (m_after_op) model_eval();
            else            m_acc = m_entry;
          end
          m_op = k[3:0]; m_after_op = 1; m_typing = 0; m_entry = 0;
        end
        KEY_EQLS: begin
          if (m_after_op) begin
            model_eval();
            m_after_op = 0; m_typing = 0; m_entry = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic nk, input logic [4:0] code);
    @(negedge clock);
    newkey  = nk;
    keycode = code;
    @(posedge clock);
    #1;
    if (reset)   model_clear();
    else if (nk) model_key(code);
    newkey = 1'b0;
  endtask

  task automatic key(input logic [4:0] code);
    step(1'b1, code);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 5'd0);
    step(1'b1, dig(5));
    reset = 1'b0;
    n_cmp++; if (value !== 16'h0000) begin n_bad++; $display("FAIL reset_value: got %h want 0000", value); end
    n_cmp++; if (sign !== 1'b0) begin n_bad++; $display("FAIL reset_sign: got %b want 0", sign); end
    n_cmp++; if (ovw !== 1'b0) begin n_bad++; $display("FAIL reset_ovw: got %b want 0", ovw); end
  endtask

  task automatic test_add();
    key(dig(1)); key(dig(2)); key(dig(3));
    n_cmp++; if (value !== 16'h0123) begin n_bad++; $display("FAIL add_entry: got %h want 0123", value); end
    key(cmd(KEY_ADD)); key(dig(4)); key(dig(5)); key(dig(6)); key(cmd(KEY_EQLS));
    n_cmp++; if (value !== 16'h0579) begin n_bad++; $display("FAIL add_value: got %h want 0579", value); end
    n_cmp++; if (sign !== 1'b0 || ovw !== 1'b0) begin n_bad++; $display("FAIL add_flags: got sign=%b ovw=%b want 0 0", sign, ovw); end
  endtask

  task automatic test_subtract_sign();
    key(cmd(KEY_SUBT)); key(dig(1)); key(dig(0)); key(dig(0)); key(dig(0)); key(cmd(KEY_EQLS));
    n_cmp++; if (value !== 16'h0A87 || sign !== 1'b1) begin n_bad++; $display("FAIL sub_neg: got %h sign=%b want 0a87 sign=1", value, sign); end
    key(cmd(KEY_ADD)); key(dig(10)); key(dig(8)); key(dig(8)); key(cmd(KEY_EQLS));
    n_cmp++; if (value !== 16'h0001 || sign !== 1'b0) begin n_bad++; $display("FAIL sub_back_pos: got %h sign=%b want 0001 sign=0", value, sign); end
  endtask

  task automatic test_overflow();
    key(dig(15)); key(dig(15)); key(dig(15)); key(dig(15));
    key(cmd(KEY_MULT)); key(dig(2)); key(cmd(KEY_EQLS));
    n_cmp++; if (ovw !== 1'b1 || value !== 16'h0000 || sign !== 1'b0) begin n_bad++; $display("FAIL ovf_set: got %h sign=%b ovw=%b want 0000 0 1", value, sign, ovw); end
    key(cmd(KEY_ADD)); key(dig(5)); key(cmd(KEY_EQLS));
    n_cmp++; if (value !== 16'h0005 || ovw !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %h ovw=%b want 0005 ovw=1", value, ovw); end
    key(cmd(KEY_CA));
    n_cmp++; if (value !== 16'h0000 || sign !== 1'b0 || ovw !== 1'b0) begin n_bad++; $display("FAIL ovf_ca: got %h sign=%b ovw=%b want 0000 0 0", value, sign, ovw); end
  endtask

  task automatic test_digit_limit();
    key(dig(10)); key(dig(11)); key(dig(12)); key(dig(13)); key(dig(14));
    n_cmp++; if (value !== 16'hABCD) begin n_bad++; $display("FAIL digit_limit: got %h want abcd", value); end
    key(cmd(KEY_BACK));
    n_cmp++; if (value !== 16'h0ABC) begin n_bad++; $display("FAIL back: got %h want 0abc", value); end
    key(cmd(KEY_CE));
    n_cmp++; if (value !== 16'h0000 || sign !== 1'b0) begin n_bad++; $display("FAIL ce: got %h sign=%b want 0000 0", value, sign); end
  endtask

  task automatic test_chaining();
    key(cmd(KEY_CA));
    key(dig(2)); key(cmd(KEY_ADD)); key(dig(3)); key(cmd(KEY_MULT));
    n_cmp++; if (value !== 16'h0005) begin n_bad++; $display("FAIL chain_mid: got %h want 0005", value); end
    key(dig(4)); key(cmd(KEY_EQLS));
    n_cmp++; if (value !== 16'h0014) begin n_bad++; $display("FAIL chain_end: got %h want 0014", value); end
    // EQLS with no second operand typed uses zero: 0x14 * 0.
    key(cmd(KEY_MULT)); key(cmd(KEY_EQLS));
    n_cmp++; if (value !== 16'h0000 || sign !== 1'b0) begin n_bad++; $display("FAIL eq_empty: got %h sign=%b want 0000 0", value, sign); end
  endtask

  task automatic test_reset_mid_entry();
    key(dig(7)); key(dig(7));
    n_cmp++; if (value !== 16'h0077) begin n_bad++; $display("FAIL mid_entry: got %h want 0077", value); end
    step(1'b0, dig(9));
    n_cmp++; if (value !== 16'h0077) begin n_bad++; $display("FAIL no_strobe: got %h want 0077", value); end
    reset = 1'b1;
    step(1'b1, dig(3));
    reset = 1'b0;
    n_cmp++; if (value !== 16'h0000 || sign !== 1'b0 || ovw !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got %h sign=%b ovw=%b want 0000 0 0", value, sign, ovw); end
    key(dig(1));
    n_cmp++; if (value !== 16'h0001) begin n_bad++; $display("FAIL after_reset: got %h want 0001", value); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  k;
    logic [15:0] exp_value;
    logic        exp_sign;
    int          pick;
    key(cmd(KEY_CA));
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 50)      k = dig($urandom_range(0, 15));
      else if (pick < 60) k = cmd(KEY_ADD);
      else if (pick < 68) k = cmd(KEY_SUBT);
      else if (pick < 76) k = cmd(KEY_MULT);
      else if (pick < 86) k = cmd(KEY_EQLS);
      else if (pick < 90) k = cmd(KEY_BACK);
      else if (pick < 93) k = cmd(KEY_CE);
      else if (pick < 94) k = cmd(KEY_CA);
      else                k = {1'b0, 4'($urandom_range(0, 15))};
      step(($urandom_range(0, 9) != 0), k);
      exp_value = m_typing ? 16'(m_entry) : 16'(m_acc < 0 ? -m_acc : m_acc);
      exp_sign  = !m_typing && (m_acc < 0);
      n_cmp++;
      if (value !== exp_value || sign !== exp_sign || ovw !== m_ovw) begin
        n_bad++;
        $display("FAIL random[%0d] key=%h: got %h sign=%b ovw=%b want %h sign=%b ovw=%b",
                 i, k, value, sign, ovw, exp_value, exp_sign, m_ovw);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    newkey  = 1'b0;
    keycode = 5'd0;
    model_clear();
    test_reset();
    test_add();
    test_subtract_sign();
    test_overflow();
    test_digit_limit();
    test_chaining();
    test_reset_mid_entry();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
